// File: rtl/comparator_stream_reducer_pkg.sv
// Shared types and the ordering helper for the comparator stream reducer.
package comparator_stream_reducer_pkg;

  // Frame FSM: absorb tree outputs, then present one result.
  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_t;

  // Widest element the combine helper handles; callers zero-extend into it.
  localparam int unsigned CMP_W = 64;

  // Returns cand when it strictly beats acc, otherwise acc (ties keep acc).
  // Signed ordering is obtained by flipping the sign bit of the element
  // width, which maps two's complement order onto unsigned order.
  function automatic logic [CMP_W-1:0] combine(
    input logic [CMP_W-1:0] acc,
    input logic [CMP_W-1:0] cand,
    input int unsigned      width,
    input bit               is_signed,
    input bit               is_max
  );
    logic [CMP_W-1:0] bias;
    logic [CMP_W-1:0] acc_key;
    logic [CMP_W-1:0] cand_key;
    logic             take;
    bias     = is_signed ? (CMP_W'(1) << (width - 1)) : '0;
    acc_key  = acc ^ bias;
    cand_key = cand ^ bias;
    take     = is_max ? (cand_key > acc_key) : (cand_key < acc_key);
    return take ? cand : acc;
  endfunction

endpackage

// File: rtl/comparator_stream_reducer_tree.sv
// Pipelined comparator tree: halves the element count at every registered
// level, so a SIZE-wide beat becomes one extreme value after log2(SIZE) edges.
// Each level is a single register slot with valid/ready flow control.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never waits on ready, and data/valid hold while valid=1 and
// ready=0.
module comparator_tree
  import comparator_stream_reducer_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX1_MIN0  = 1,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int LEVELS = $clog2(SIZE);

  genvar lv;
  for (lv = 0; lv < LEVELS; lv++) begin : g_lvl
    localparam int N_OUT = int'(SIZE) >> (lv + 1);

    logic [2*N_OUT-1:0][DATA_WIDTH-1:0] d;
    logic                               d_valid;
    logic [N_OUT-1:0][DATA_WIDTH-1:0]   q;
    logic                               q_valid;
    logic                               down_ready;
    logic                               up_ready;

    if (lv == 0) begin : g_head
      assign d       = in_data;
      assign d_valid = in_valid;
    end else begin : g_link
      assign d       = g_lvl[lv-1].q;
      assign d_valid = g_lvl[lv-1].q_valid;
    end

    if (lv == LEVELS - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_mid
      assign down_ready = g_lvl[lv+1].up_ready;
    end

    // The slot can take new data when empty or when it drains this edge.
    assign up_ready = !q_valid || down_ready;

    // Pairwise reduce the incoming elements into this level's register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_valid <= 1'b0;
        q       <= '0;
      end else if (up_ready) begin
        q_valid <= d_valid;
        for (int e = 0; e < N_OUT; e++) begin
          q[e] <= DATA_WIDTH'(combine(CMP_W'(d[2*e]), CMP_W'(d[2*e+1]),
                                      DATA_WIDTH, SIGNED != 0, MAX1_MIN0 != 0));
        end
      end
    end
  end

  assign in_ready  = g_lvl[0].up_ready;
  assign out_data  = g_lvl[LEVELS-1].q[0];
  assign out_valid = g_lvl[LEVELS-1].q_valid;

endmodule

// File: rtl/comparator_stream_reducer.sv
// Comparator stream reducer: folds every BLOCKS accepted beats into one max
// or min result. A comparator tree reduces each beat; a local accumulator and
// a two-state FSM fold the tree outputs of a frame and present the result.
//
// Handshake (both in_* and out_*): a transfer happens on a rising edge where
// valid and ready are both 1; a source holds valid and data stable until that
// edge.
module comparator_stream_reducer
  import comparator_stream_reducer_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX1_MIN0  = 1,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned BLOCKS     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]   in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(BLOCKS+1)-1:0]       out_count
);

  localparam int unsigned CW = $clog2(BLOCKS + 1);

  logic [DATA_WIDTH-1:0] tree_data;
  logic                  tree_valid;
  logic                  tree_ready;
  logic                  tree_fire;

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] result;
  logic                  frame_last;

  comparator_tree #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX1_MIN0  (MAX1_MIN0),
    .SIGNED     (SIGNED)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (tree_data),
    .out_valid (tree_valid),
    .out_ready (tree_ready)
  );

  assign tree_fire  = tree_valid && tree_ready;
  assign frame_last = (count == CW'(BLOCKS - 1));

  // The first tree output of a frame seeds the fold; later ones combine with
  // it. With BLOCKS=1 the seed is also the result, so no stale acc leaks in.
  assign merged = (count == '0) ? tree_data
                : DATA_WIDTH'(combine(CMP_W'(acc), CMP_W'(tree_data),
                                      DATA_WIDTH, SIGNED != 0, MAX1_MIN0 != 0));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs: tree drains only while accumulating,
  // and the result is offered only in OUTPUT.
  always_comb begin
    state_next = state;
    tree_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        tree_ready = 1'b1;
        if (tree_valid && frame_last) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Accumulator, beat counter and result register advance on tree handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      result <= '0;
    end else if (tree_fire) begin
      acc <= merged;
      if (frame_last) begin
        count  <= '0;
        result <= merged;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign out_data  = result;
  assign out_count = count;

endmodule
